seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_shift.sv | 57 +++++
 rtl/seq_gen.sv | 135 +++++++++++++
 tb/tb_seq_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator and the sequence detector:
// FSM state encoding and default parameter values.
package seq_pkg;

    localparam int W_DEF   = 8;
    localparam int GAP_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_shift.sv
// Loadable pattern register with a bit-index down-counter.
// The index points at the bit currently on the serial line; nbit is the bit
// that will be on the line after the coming edge, so the parent can register it.
module seq_shift
    import seq_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 load,
    input  logic                 adv,
    input  logic [W-1:0]         pat,
    input  logic [$clog2(W)-1:0] len,
    output logic                 nbit,
    output logic                 last
);

    localparam int LW = $clog2(W);

    logic [W-1:0]  pat_r;
    logic [W-1:0]  pat_n;
    logic [LW-1:0] len_r;
    logic [LW-1:0] idx_r;
    logic [LW-1:0] idx_n;

    // Next pattern/index: load captures a fresh pattern, advance steps down
    // and reloads from the captured length instead of wrapping below zero.
    always_comb begin
        pat_n = pat_r;
        idx_n = idx_r;
        if (load) begin
            pat_n = pat;
            idx_n = len;
        end else if (adv) begin
            idx_n = (idx_r == '0) ? len_r : idx_r - LW'(1);
        end
    end

    // Pattern, length and index registers.
    always_ff @(posedge clk) begin
        if (res) begin
            pat_r <= '0;
            len_r <= '0;
            idx_r <= '0;
        end else begin
            pat_r <= pat_n;
            idx_r <= idx_n;
            if (load)
                len_r <= len;
        end
    end

    assign nbit = pat_n[idx_n];
    assign last = (idx_r == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends pat[len:0] MSB-first, rep times, with GAP
// idle cycles between repetitions, then pulses done. All outputs registered.
module seq_gen
    import seq_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int GAP = GAP_DEF
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic [W-1:0]         pat,
    input  logic [$clog2(W)-1:0] len,
    input  logic [3:0]           rep,
    output logic                 x,
    output logic                 xv,
    output logic                 busy,
    output logic                 done
);

    state_t     state;
    state_t     state_n;
    logic [3:0] rep_r;
    logic [3:0] gap_r;
    logic       load;
    logic       adv;
    logic       nbit;
    logic       last;
    logic       x_n;
    logic       xv_n;
    logic       busy_n;
    logic       done_n;

    seq_shift #(
        .W(W)
    ) u_shift (
        .clk  (clk),
        .res  (res),
        .load (load),
        .adv  (adv),
        .pat  (pat),
        .len  (len),
        .nbit (nbit),
        .last (last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (res)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_n = ST_SEND;
            end
            ST_SEND: begin
                if (last) begin
                    if (rep_r == 4'd1)
                        state_n = ST_DONE;
                    else if (GAP > 0)
                        state_n = ST_GAP;
                    else
                        state_n = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_r == '0)
                    state_n = ST_SEND;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Output decode: shifter controls and the next values of the output flops,
    // derived from the next state so the registered outputs line up with it.
    always_comb begin
        load   = (state == ST_IDLE) && start;
        adv    = (state == ST_SEND);
        xv_n   = (state_n == ST_SEND);
        x_n    = xv_n & nbit;
        busy_n = (state_n != ST_IDLE);
        done_n = (state_n == ST_DONE);
    end

    // Repetition and gap counters.
    always_ff @(posedge clk) begin
        if (res) begin
            rep_r <= '0;
            gap_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start)
                        rep_r <= (rep == '0) ? 4'd1 : rep;
                end
                ST_SEND: begin
                    if (last) begin
                        rep_r <= rep_r - 4'd1;
                        if (state_n == ST_GAP)
                            gap_r <= 4'(GAP - 1);
                    end
                end
                ST_GAP: begin
                    if (gap_r != '0)
                        gap_r <= gap_r - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (res) begin
            x    <= 1'b0;
            xv   <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            x    <= x_n;
            xv   <= xv_n;
            busy <= busy_n;
            done <= done_n;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: one instance with GAP=2, one with GAP=0.
// Stimulus pushes the expected per-cycle output tuples; monitors pop and
// compare whenever an instance shows any activity.
module tb_seq_gen;

    typedef struct packed {
        logic busy;
        logic xv;
        logic x;
        logic done;
    } samp_t;

    logic       clk = 1'b0;
    logic       res;
    logic       start2;
    logic       start0;
    logic [7:0] pat;
    logic [2:0] len;
    logic [3:0] rep;
    logic       x2, xv2, busy2, done2;
    logic       x0, xv0, busy0, done0;

    samp_t q2[$];
    samp_t q0[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    bit    mon_en   = 1'b0;

    always #5 clk = ~clk;

    seq_gen #(.W(8), .GAP(2)) u_gap2 (
        .clk(clk), .res(res), .start(start2), .pat(pat), .len(len), .rep(rep),
        .x(x2), .xv(xv2), .busy(busy2), .done(done2)
    );

    seq_gen #(.W(8), .GAP(0)) u_gap0 (
        .clk(clk), .res(res), .start(start0), .pat(pat), .len(len), .rep(rep),
        .x(x0), .xv(xv0), .busy(busy0), .done(done0)
    );

    function automatic samp_t mk(input logic b, input logic v, input logic d, input logic dn);
        samp_t s;
        s.busy = b; s.xv = v; s.x = d; s.done = dn;
        return s;
    endfunction

    // Expected stream: bits pat[len]..pat[0] per repetition, gap cycles between, then done.
    function automatic void push_model(input bit to0, input logic [7:0] p, input int l,
                                       input int r, input int gap);
        int reps;
        reps = (r == 0) ? 1 : r;
        for (int k = 0; k < reps; k++) begin
            for (int i = l; i >= 0; i--) begin
                if (to0) q0.push_back(mk(1'b1, 1'b1, p[i], 1'b0));
                else     q2.push_back(mk(1'b1, 1'b1, p[i], 1'b0));
            end
            if (k < reps - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (to0) q0.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
                    else     q2.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
                end
            end
        end
        if (to0) q0.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
        else     q2.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1));
    endfunction

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy/xv/x/done=%b, required %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor for the GAP=2 instance.
    always @(negedge clk) begin
        samp_t a, e;
        a = {busy2, xv2, x2, done2};
        if (mon_en && a !== 4'b0000) begin
            n_checks++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL gap2_unexpected: got busy/xv/x/done=%b, required no activity at %0t", a, $time);
            end else begin
                e = q2.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL gap2_stream: got busy/xv/x/done=%b, required %b at %0t", a, e, $time);
                end
            end
        end
    end

    // Monitor for the GAP=0 instance.
    always @(negedge clk) begin
        samp_t a, e;
        a = {busy0, xv0, x0, done0};
        if (mon_en && a !== 4'b0000) begin
            n_checks++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL gap0_unexpected: got busy/xv/x/done=%b, required no activity at %0t", a, $time);
            end else begin
                e = q0.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL gap0_stream: got busy/xv/x/done=%b, required %b at %0t", a, e, $time);
                end
            end
        end
    end

    task automatic drain(input string nm);
        for (int c = 0; c < 400; c++) begin
            if (q0.size() == 0 && q2.size() == 0) break;
            @(posedge clk);
        end
        n_checks++;
        if (q0.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d/%0d outputs still pending, required 0/0", nm, q2.size(), q0.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic issue2(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
        pat = p; len = l; rep = r; start2 = 1'b1;
        push_model(1'b0, p, int'(l), int'(r), 2);
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic issue0(input logic [7:0] p, input logic [2:0] l, input logic [3:0] r);
        pat = p; len = l; rep = r; start0 = 1'b1;
        push_model(1'b1, p, int'(l), int'(r), 0);
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res = 1'b1; start2 = 1'b0; start0 = 1'b0; pat = '0; len = '0; rep = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gap2", {busy2, xv2, x2, done2}, 4'b0000);
        chk("reset_gap0", {busy0, xv0, x0, done0}, 4'b0000);
        @(posedge clk); #1;
        res = 1'b0;
        mon_en = 1'b1;

        // 1001, single repetition
        issue2(8'b0000_1001, 3'd3, 4'd1);
        drain("single");

        // two repetitions with a 2-cycle gap
        issue2(8'b0000_1001, 3'd3, 4'd2);
        drain("rep2");

        // rep=0 acts as 1; start pulsed while busy is ignored
        issue2(8'b0000_1001, 3'd3, 4'd0);
        start2 = 1'b1; pat = 8'hFF; len = 3'd7; rep = 4'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start2 = 1'b0;
        drain("rep0_busy_start");

        // inputs changed mid-transfer use the captured copies
        issue2(8'hA5, 3'd7, 4'd2);
        repeat (3) @(posedge clk);
        #1;
        pat = 8'h3C; len = 3'd1; rep = 4'd5;
        drain("midchange");

        // start held through DONE is only accepted on the first IDLE cycle
        issue2(8'b0000_1001, 3'd3, 4'd1);
        repeat (4) @(posedge clk);
        #1;
        start2 = 1'b1; pat = 8'b0000_0110; len = 3'd3; rep = 4'd1;
        @(posedge clk); #1;
        push_model(1'b0, 8'b0000_0110, 3, 1, 2);
        @(negedge clk);
        chk("idle_after_done", {busy2, xv2, x2, done2}, 4'b0000);
        @(posedge clk); #1;
        start2 = 1'b0;
        drain("start_in_done");

        // reset during the second bit aborts without done
        pat = 8'b0000_1011; len = 3'd3; rep = 4'd1; start2 = 1'b1;
        q2.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
        q2.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        start2 = 1'b0;
        @(posedge clk); #1;
        res = 1'b1;
        @(posedge clk); #1;
        res = 1'b0;
        @(negedge clk);
        chk("reset_mid_send", {busy2, xv2, x2, done2}, 4'b0000);
        drain("reset_mid");

        // new transfer after reset starts from pat[len]
        issue2(8'b0000_0110, 3'd3, 4'd1);
        drain("after_reset");

        // reset wins over start in the same cycle
        res = 1'b1; start2 = 1'b1; pat = 8'hFF; len = 3'd2; rep = 4'd1;
        @(posedge clk); #1;
        res = 1'b0; start2 = 1'b0;
        @(negedge clk);
        chk("reset_priority", {busy2, xv2, x2, done2}, 4'b0000);
        drain("reset_priority");

        // GAP=0: len=0, pat[0]=1, three back-to-back single-bit repetitions
        issue0(8'b0000_0001, 3'd0, 4'd3);
        drain("gap0_len0");

        // GAP=0: repetitions with no bubble
        issue0(8'b0000_1001, 3'd3, 4'd2);
        drain("gap0_rep2");

        // GAP=0: single zero bit
        issue0(8'b1111_1110, 3'd0, 4'd1);
        drain("gap0_zero");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
